inst_fetch_unit: RTL and testbench

//  Instruction fetch front end; drives the synchronous instruction memory and

---
 rtl/inst_fetch_unit.sv | 137 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch front end: PC, one-read-per-cycle issue, tagged fetch buffer
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [31:0]   fifo_inst_q [FIFO_DEPTH];
  logic [31:0]   fifo_inst_d [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]   fifo_pc_d   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   occupancy;
  logic          unused_redirect_lsbs;

  assign imem_addr            = pc_q;
  assign out_valid            = (count_q != '0);
  assign out_inst             = fifo_inst_q[rd_ptr_q];
  assign out_pc               = fifo_pc_q[rd_ptr_q];
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credit check counts the in-flight read so a returning word always has a free slot.
  always_comb begin
    pop       = out_valid & out_ready;
    push      = inflight_q & ~redirect_valid;
    occupancy = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    issue     = ~halt & ~redirect_valid & (occupancy < (CW+1)'(FIFO_DEPTH));

    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    fifo_inst_d   = fifo_inst_q;
    fifo_pc_d     = fifo_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_inst_d[wr_ptr_q] = imem_inst;
        fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (issue) begin
        pc_d          = pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      fifo_inst_q   <= fifo_inst_d;
      fifo_pc_q     <= fifo_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Counters survive redirects; a pop in a redirect cycle is still an accepted fetch.
  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop);
    perf_stall_d   = perf_stall_q + 32'(out_valid & ~out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit against an in-order stream model
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr, imem_inst;
  logic        halt, redirect_valid, out_valid, out_ready;
  logic [31:0] redirect_pc, out_inst, out_pc;
  logic [31:0] w_imem_addr, w_imem_inst, w_out_inst, w_out_pc;
  logic        w_out_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc, w_exp_pc;
  int          pops, stall_exp;

  inst_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_imem_addr), .imem_inst(w_imem_inst),
    .halt(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_inst(w_out_inst), .out_pc(w_out_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(w_perf_fetched), .perf_stall(w_perf_stall)
`endif
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    imem_inst   <= rom_word(imem_addr);
    w_imem_inst <= rom_word(w_imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, score any pop against the expected stream, step to next negedge.
  task automatic cycle(input logic rdy, input logic hlt, input logic rv, input logic [31:0] rpc);
    logic [31:0] addr_before;
    out_ready      = rdy;
    halt           = hlt;
    redirect_valid = rv;
    redirect_pc    = rpc;
    addr_before    = imem_addr;
    if (out_valid && rdy) begin
      check("pop_pc", out_pc, exp_pc);
      check("pop_inst", out_inst, rom_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (out_valid && !rdy) stall_exp++;
    if (w_out_valid) begin
      check("wrap_pc", w_out_pc, w_exp_pc);
      check("wrap_inst", w_out_inst, rom_word(w_exp_pc));
      w_exp_pc = w_exp_pc + 32'd4;
    end
    if (rv) exp_pc = {rpc[31:2], 2'b00};
    @(negedge clk);
    if (rv) begin
      check("redir_addr", imem_addr, exp_pc);
      check("redir_flush", 32'(out_valid), 32'd0);
    end else if (hlt) begin
      check("halt_frozen", imem_addr, addr_before);
    end
  endtask

  task automatic model_reset();
    exp_pc    = 32'h0;
    w_exp_pc  = 32'hFFFF_FFF8;
    pops      = 0;
    stall_exp = 0;
  endtask

  initial begin
    logic [31:0] frozen_addr;
    int          p0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall0;
`endif
    rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFF8);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_stall", perf_stall, 32'h0);
`endif

    rst_n = 1'b1;
    cycle(1, 0, 0, 0);
    check("first_lat1", 32'(out_valid), 32'd0);
    cycle(1, 0, 0, 0);
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_pc", out_pc, 32'h0);
    check("first_inst", out_inst, 32'hA000_0000);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0, 0);
      check("sustained", 32'(out_valid), 32'd1);
    end

`ifdef FETCH_PERF_CNT_EN
    stall0 = perf_stall;
`endif
    frozen_addr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0);
      if (i == 2) frozen_addr = imem_addr;
    end
    check("stall_frozen", imem_addr, frozen_addr);
    check("stall_valid", 32'(out_valid), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("stall_perf10", perf_stall - stall0, 32'd10);
`endif
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0);

    cycle(1, 0, 1, 32'h0000_0103);
    cycle(1, 0, 0, 0);
    check("redir_lat1", 32'(out_valid), 32'd0);
    cycle(1, 0, 0, 0);
    check("redir_valid", 32'(out_valid), 32'd1);
    check("redir_pc", out_pc, 32'h100);
    check("redir_inst", out_inst, 32'hA000_0040);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);

    cycle(1, 0, 1, 32'h200);
    cycle(1, 0, 1, 32'h300);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("b2b_pc", out_pc, 32'h300);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);

    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
    check("halt_drain", 32'(out_valid), 32'd0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0);

    p0 = pops;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(3) != 0, $urandom_range(6) == 0, $urandom_range(19) == 0,
            $urandom & 32'h0000_0FFF);
    end
    check("rand_progress", 32'(pops - p0 > 50), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'(pops));
    check("perf_stall", perf_stall, 32'(stall_exp));
`endif

    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_addr", imem_addr, 32'h0);
    check("async_wrap_addr", w_imem_addr, 32'hFFFF_FFF8);
`ifdef FETCH_PERF_CNT_EN
    check("async_perf", perf_fetched, 32'h0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 0, 0);
    check("rerun_lat1", 32'(out_valid), 32'd0);
    cycle(1, 0, 0, 0);
    check("rerun_valid", 32'(out_valid), 32'd1);
    check("rerun_pc", out_pc, 32'h0);
    check("rerun_inst", out_inst, 32'hA000_0000);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
